dmem_arbiter: RTL

- Two-requester arbiter and sequencer in front of the single-port, byte-addressed, little-endian 64-bit `data_memory`.
- Port 0 is the core load/store path; port 1 is the debug/loader path.
- Accepts one request at a time over valid/ready and drives exactly one memory access cycle per request.
- Returns a registered response pulse to the granted requester, with bounds checking against memory size.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arbiter_rr_arb2.sv | 56 +++++
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional build macro used by this block: DMEM_ARB_FIXED_PRIO_EN.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  localparam int PORT_CORE    = 0;
  localparam int PORT_DBG     = 1;
  localparam int ACCESS_BYTES = 8;

  // Index of the granted port from a one-hot grant vector.
  function automatic logic gnt_to_port(input logic [1:0] gnt);
    return gnt[PORT_DBG];
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input grant logic for the data-memory arbiter.
// Default build: round-robin, a tie goes to the port that did not win last.
// With DMEM_ARB_FIXED_PRIO_EN defined: port 0 always wins a tie.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

`ifdef DMEM_ARB_FIXED_PRIO_EN

  // Core port has absolute priority; history is not tracked.
  always_comb begin
    gnt = 2'b00;
    if (req[PORT_CORE]) begin
      gnt[PORT_CORE] = 1'b1;
    end else if (req[PORT_DBG]) begin
      gnt[PORT_DBG] = 1'b1;
    end
  end

  logic w_unused;
  assign w_unused = &{1'b0, clk, reset, accept};

`else

  // 1 = debug port won most recently; reset value lets the core win first.
  logic r_last_grant;

  // Remember the winner of each accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (accept && (gnt != 2'b00)) begin
      r_last_grant <= gnt_to_port(gnt);
    end
  end

  // Single requester always wins; on a tie the other port gets its turn.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port 64-bit data memory.
// Each accepted request takes one ACCESS cycle and returns a one-cycle
// registered response pulse to the port that issued it.
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN (fixed priority, port 0 wins).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic              r0_req_we,
  input  logic [ADDR_W-1:0] r0_req_addr,
  input  logic [DATA_W-1:0] r0_req_wdata,
  output logic              r0_rsp_valid,
  output logic [DATA_W-1:0] r0_rsp_rdata,
  output logic              r0_rsp_err,

  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic              r1_req_we,
  input  logic [ADDR_W-1:0] r1_req_addr,
  input  logic [DATA_W-1:0] r1_req_wdata,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] r1_rsp_rdata,
  output logic              r1_rsp_err,

  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  // Highest start address whose 8-byte window still fits. A plain compare
  // against this bound also rejects addresses where addr+7 would wrap.
  localparam logic [ADDR_W-1:0] LAST_LEGAL = ADDR_W'(MEM_BYTES - ACCESS_BYTES);

  arb_state_t        r_state;
  arb_state_t        w_state_next;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_port;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_accept;
  logic              w_in_range;

  logic [1:0]        r_rsp_valid;
  logic [1:0]        r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata [2];

  assign w_req      = {r1_req_valid, r0_req_valid};
  assign w_accept   = (r_state == IDLE) && (w_req != 2'b00) && !reset;
  assign w_in_range = (r_addr <= LAST_LEGAL);

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (w_req),
    .accept (w_accept),
    .gnt    (w_gnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, ready handshake and memory strobes.
  always_comb begin
    w_state_next   = r_state;
    r0_req_ready   = 1'b0;
    r1_req_ready   = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = ACCESS;
          r0_req_ready = w_gnt[PORT_CORE];
          r1_req_ready = w_gnt[PORT_DBG];
        end
      end
      ACCESS: begin
        w_state_next   = IDLE;
        mem_address    = r_addr;
        mem_write_data = r_wdata;
        mem_read       = !r_we && w_in_range;
        // A reset landing in ACCESS must not let the write commit.
        mem_write      = r_we && w_in_range && !reset;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Capture the winning request's payload at accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_port  <= 1'b0;
    end else if (w_accept) begin
      r_port  <= gnt_to_port(w_gnt);
      r_we    <= w_gnt[PORT_DBG] ? r1_req_we    : r0_req_we;
      r_addr  <= w_gnt[PORT_DBG] ? r1_req_addr  : r0_req_addr;
      r_wdata <= w_gnt[PORT_DBG] ? r1_req_wdata : r0_req_wdata;
    end
  end

  // Response pulse at the close of ACCESS; read data holds until the next
  // response on the same port, valid/err last only one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 2'b00;
      r_rsp_err   <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_rsp_rdata[i] <= '0;
      end
    end else begin
      r_rsp_valid <= 2'b00;
      r_rsp_err   <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if ((r_state == ACCESS) && (r_port == 1'(i))) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_err[i]   <= !w_in_range;
          r_rsp_rdata[i] <= (!r_we && w_in_range) ? mem_read_data : '0;
        end
      end
    end
  end

  assign r0_rsp_valid = r_rsp_valid[PORT_CORE];
  assign r0_rsp_err   = r_rsp_err[PORT_CORE];
  assign r0_rsp_rdata = r_rsp_rdata[PORT_CORE];
  assign r1_rsp_valid = r_rsp_valid[PORT_DBG];
  assign r1_rsp_err   = r_rsp_err[PORT_DBG];
  assign r1_rsp_rdata = r_rsp_rdata[PORT_DBG];

endmodule
